// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - two-port arbiter sharing one sdram_ctl between CPU (port 0) and DMA (port 1)
// One complete sdram_ctl operation per grant; registered ack/err/rdata back to the granted port.
module sdram_arbiter #(
    parameter int ADDR_W     = 25,
    parameter int DATA_W     = 16,
    parameter int FIXED_PRIO = 0,
    parameter int MAX_WAIT   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              ctl_write_en,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic [DATA_W-1:0] ctl_data_in,
    output logic              ctl_refresh_data,
    input  logic [DATA_W-1:0] ctl_data_out,
    input  logic              ctl_data_ready,
    output logic              busy,
    output logic              grant
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [1:0]        r_state;
    logic              r_last_grant;
    logic              r_grant;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ctl_we;
    logic [ADDR_W-1:0] r_ctl_addr;
    logic [DATA_W-1:0] r_ctl_din;
    logic              r_ctl_ref;
    logic              r_busy;
    logic              r_p0_ack, r_p1_ack, r_p0_err, r_p1_err;
    logic [DATA_W-1:0] r_p0_rdata, r_p1_rdata;

    logic w_any;
    logic w_pick;
    logic w_timeout;
    logic w_done;
    logic w_fail;

    always_comb begin
        w_any = p0_req | p1_req;
        if (p0_req && p1_req)
            w_pick = (FIXED_PRIO != 0) ? 1'b0 : ~r_last_grant;
        else
            w_pick = p1_req;
        w_timeout = (r_cnt == CNT_W'(MAX_WAIT - 1));
        w_done    = (r_state == S_WAIT) && ctl_data_ready;
        // ISSUE times out only while the controller has not yet accepted; WAIT only while not done
        w_fail    = w_timeout && (((r_state == S_ISSUE) && ctl_data_ready) ||
                                  ((r_state == S_WAIT) && !ctl_data_ready));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_cnt        <= '0;
            r_ctl_we     <= 1'b0;
            r_ctl_addr   <= '0;
            r_ctl_din    <= '0;
            r_ctl_ref    <= 1'b0;
            r_busy       <= 1'b0;
            r_p0_ack     <= 1'b0;
            r_p1_ack     <= 1'b0;
            r_p0_err     <= 1'b0;
            r_p1_err     <= 1'b0;
            r_p0_rdata   <= '0;
            r_p1_rdata   <= '0;
        end else begin
            r_p0_ack <= 1'b0;
            r_p1_ack <= 1'b0;
            r_p0_err <= 1'b0;
            r_p1_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant      <= w_pick;
                        r_last_grant <= w_pick;
                        r_ctl_we     <= w_pick ? p1_we    : p0_we;
                        r_ctl_addr   <= w_pick ? p1_addr  : p0_addr;
                        r_ctl_din    <= w_pick ? p1_wdata : p0_wdata;
                        r_ctl_ref    <= 1'b1;
                        r_cnt        <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE, S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_done || w_fail) begin
                        r_ctl_ref <= 1'b0;
                        r_state   <= S_RESP;
                        // ack is registered here so it is high for exactly the RESP cycle
                        if (r_grant) begin
                            r_p1_ack <= 1'b1;
                            r_p1_err <= w_fail;
                            if (w_done && !r_ctl_we)
                                r_p1_rdata <= ctl_data_out;
                        end else begin
                            r_p0_ack <= 1'b1;
                            r_p0_err <= w_fail;
                            if (w_done && !r_ctl_we)
                                r_p0_rdata <= ctl_data_out;
                        end
                    end else if ((r_state == S_ISSUE) && !ctl_data_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign p0_ack           = r_p0_ack;
    assign p0_err           = r_p0_err;
    assign p0_rdata         = r_p0_rdata;
    assign p1_ack           = r_p1_ack;
    assign p1_err           = r_p1_err;
    assign p1_rdata         = r_p1_rdata;
    assign ctl_write_en     = r_ctl_we;
    assign ctl_addr         = r_ctl_addr;
    assign ctl_data_in      = r_ctl_din;
    assign ctl_refresh_data = r_ctl_ref;
    assign busy             = r_busy;
    assign grant            = r_grant;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - self-checking bench for sdram_arbiter (round-robin and fixed-priority instances)
module tb_sdram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // index 0: round-robin instance, index 1: fixed-priority instance
    logic        req0[2], req1[2], we0[2], we1[2];
    logic [24:0] addr0[2], addr1[2];
    logic [15:0] wd0[2], wd1[2];
    wire         ack0[2], ack1[2], err0[2], err1[2];
    wire  [15:0] rd0[2], rd1[2];
    wire         c_we[2], c_ref[2], busy[2], grant[2];
    wire  [24:0] c_addr[2];
    wire  [15:0] c_din[2];
    logic [15:0] c_dout[2];
    logic        c_rdy[2];
    logic        stuck[2];
    logic [1:0]  m_st[2];
    logic [2:0]  m_cnt[2];
    logic [15:0] mem[2][16];

    typedef struct {int k; int p; logic err; logic [15:0] rd;} exp_t;
    typedef struct {int k; int p; logic we; logic [24:0] a; logic [15:0] d; logic [15:0] exp_rd;} vec_t;
    exp_t sb[$];
    vec_t tbl[10];
    int checks = 0;
    int errors = 0;

    sdram_arbiter #(.ADDR_W(25), .DATA_W(16), .FIXED_PRIO(0), .MAX_WAIT(16)) u_rr (
        .clk(clk), .rst(rst_n),
        .p0_req(req0[0]), .p0_we(we0[0]), .p0_addr(addr0[0]), .p0_wdata(wd0[0]),
        .p0_ack(ack0[0]), .p0_err(err0[0]), .p0_rdata(rd0[0]),
        .p1_req(req1[0]), .p1_we(we1[0]), .p1_addr(addr1[0]), .p1_wdata(wd1[0]),
        .p1_ack(ack1[0]), .p1_err(err1[0]), .p1_rdata(rd1[0]),
        .ctl_write_en(c_we[0]), .ctl_addr(c_addr[0]), .ctl_data_in(c_din[0]),
        .ctl_refresh_data(c_ref[0]), .ctl_data_out(c_dout[0]), .ctl_data_ready(c_rdy[0]),
        .busy(busy[0]), .grant(grant[0])
    );

    sdram_arbiter #(.ADDR_W(25), .DATA_W(16), .FIXED_PRIO(1), .MAX_WAIT(16)) u_fp (
        .clk(clk), .rst(rst_n),
        .p0_req(req0[1]), .p0_we(we0[1]), .p0_addr(addr0[1]), .p0_wdata(wd0[1]),
        .p0_ack(ack0[1]), .p0_err(err0[1]), .p0_rdata(rd0[1]),
        .p1_req(req1[1]), .p1_we(we1[1]), .p1_addr(addr1[1]), .p1_wdata(wd1[1]),
        .p1_ack(ack1[1]), .p1_err(err1[1]), .p1_rdata(rd1[1]),
        .ctl_write_en(c_we[1]), .ctl_addr(c_addr[1]), .ctl_data_in(c_din[1]),
        .ctl_refresh_data(c_ref[1]), .ctl_data_out(c_dout[1]), .ctl_data_ready(c_rdy[1]),
        .busy(busy[1]), .grant(grant[1])
    );

    // sdram_ctl stand-in: ready drops on accept, op completes 3 cycles later, waits for refresh low
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_st[k]   <= 2'd0;
                m_cnt[k]  <= 3'd0;
                c_rdy[k]  <= 1'b1;
                c_dout[k] <= 16'h0;
            end else if (stuck[k]) begin
                c_rdy[k] <= 1'b1;
            end else begin
                case (m_st[k])
                    2'd0: if (c_ref[k]) begin
                        c_rdy[k] <= 1'b0;
                        m_cnt[k] <= 3'd2;
                        m_st[k]  <= 2'd1;
                    end
                    2'd1: if (m_cnt[k] == 3'd0) begin
                        if (c_we[k]) mem[k][c_addr[k][3:0]] <= c_din[k];
                        else         c_dout[k] <= mem[k][c_addr[k][3:0]];
                        c_rdy[k] <= 1'b1;
                        m_st[k]  <= 2'd2;
                    end else begin
                        m_cnt[k] <= m_cnt[k] - 3'd1;
                    end
                    default: if (!c_ref[k]) m_st[k] <= 2'd0;
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push(input int k, input int p, input logic err, input logic [15:0] rd);
        exp_t e;
        e.k = k; e.p = p; e.err = err; e.rd = rd;
        sb.push_back(e);
    endtask

    task automatic set_port(input int k, input int p, input logic r, input logic w,
                            input logic [24:0] a, input logic [15:0] d);
        if (p == 0) begin
            req0[k] = r; we0[k] = w; addr0[k] = a; wd0[k] = d;
        end else begin
            req1[k] = r; we1[k] = w; addr1[k] = a; wd1[k] = d;
        end
    endtask

    task automatic check_zero(input int k);
        chk("rst_ctl_bits", {24'd0, ack0[k], ack1[k], err0[k], err1[k], c_we[k], c_ref[k], busy[k], grant[k]}, 32'd0);
        chk("rst_rdata", {rd0[k], rd1[k]}, 32'd0);
        chk("rst_ctl_addr", {7'd0, c_addr[k]}, 32'd0);
        chk("rst_ctl_din", {16'd0, c_din[k]}, 32'd0);
    endtask

    task automatic run_op(input vec_t v);
        int n;
        set_port(v.k, v.p, 1'b1, v.we, v.a, v.d);
        push(v.k, v.p, 1'b0, v.exp_rd);
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if ((v.p == 0) ? ack0[v.k] : ack1[v.k]) break;
        end
        if (n == 100) begin
            checks++; errors++;
            $display("FAIL op_ack_timeout: dut %0d port %0d got no ack in 100 cycles", v.k, v.p);
        end
        set_port(v.k, v.p, 1'b0, 1'b0, 25'd0, 16'd0);
        @(negedge clk);
    endtask

    task automatic run_both(input int k, input int n0, input int n1);
        int c0 = 0;
        int c1 = 0;
        int n;
        req0[k] = 1'b1;
        req1[k] = 1'b1;
        for (n = 0; n < 400; n++) begin
            @(negedge clk);
            if (ack0[k]) begin c0++; if (c0 >= n0) req0[k] = 1'b0; end
            if (ack1[k]) begin c1++; if (c1 >= n1) req1[k] = 1'b0; end
            if (c0 >= n0 && c1 >= n1) break;
        end
        if (n == 400) begin
            checks++; errors++;
            $display("FAIL both_timeout: dut %0d acks p0=%0d p1=%0d required %0d/%0d", k, c0, c1, n0, n1);
        end
        req0[k] = 1'b0;
        req1[k] = 1'b0;
        @(negedge clk);
    endtask

    // scoreboard: every ack pops the oldest expectation
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int p = 0; p < 2; p++) begin
                    exp_t e;
                    if ((p == 0) ? ack0[k] : ack1[k]) begin
                        if (sb.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_ack: dut %0d port %0d acked, required no ack", k, p);
                        end else begin
                            e = sb.pop_front();
                            chk("ack_dut_port", k * 2 + p, e.k * 2 + e.p);
                            chk("ack_err", {31'd0, (p == 0) ? err0[k] : err1[k]}, {31'd0, e.err});
                            chk("ack_rdata", {16'd0, (p == 0) ? rd0[k] : rd1[k]}, {16'd0, e.rd});
                            chk("ack_grant", {31'd0, grant[k]}, p);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int nref;
        tbl[0] = '{0, 0, 1'b1, 25'd0, 16'h00ff, 16'h0000};
        tbl[1] = '{0, 0, 1'b0, 25'd0, 16'h0000, 16'h00ff};
        tbl[2] = '{0, 0, 1'b1, 25'd1, 16'h1234, 16'h00ff};
        tbl[3] = '{0, 1, 1'b0, 25'd1, 16'h0000, 16'h1234};
        tbl[4] = '{0, 1, 1'b1, 25'd1, 16'h00fe, 16'h1234};
        tbl[5] = '{1, 1, 1'b1, 25'd0, 16'h00ff, 16'h0000};
        tbl[6] = '{1, 1, 1'b1, 25'd1, 16'h00fe, 16'h0000};
        tbl[7] = '{1, 0, 1'b0, 25'd1, 16'h0000, 16'h00fe};
        tbl[8] = '{1, 1, 1'b0, 25'd0, 16'h0000, 16'h00ff};
        tbl[9] = '{1, 0, 1'b1, 25'd2, 16'ha5a5, 16'h00fe};

        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            stuck[k] = 1'b0;
            set_port(k, 0, 1'b0, 1'b0, 25'd0, 16'd0);
            set_port(k, 1, 1'b0, 1'b0, 25'd0, 16'd0);
        end
        repeat (3) @(negedge clk);
        check_zero(0);
        check_zero(1);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_op(tbl[i]);
        chk("mem0_after_write", {16'd0, mem[0][0]}, 32'h00ff);
        chk("p0_rdata_unchanged", {16'd0, rd0[0]}, 32'h00ff);

        // round-robin: last grant was port 1, so order is 0,1,0,1
        set_port(0, 0, 1'b0, 1'b0, 25'd0, 16'd0);
        set_port(0, 1, 1'b0, 1'b0, 25'd1, 16'd0);
        push(0, 0, 1'b0, 16'h00ff); push(0, 1, 1'b0, 16'h00fe);
        push(0, 0, 1'b0, 16'h00ff); push(0, 1, 1'b0, 16'h00fe);
        run_both(0, 2, 2);

        // fixed priority: port 0 wins until it drops its request
        set_port(1, 0, 1'b0, 1'b0, 25'd0, 16'd0);
        set_port(1, 1, 1'b0, 1'b0, 25'd1, 16'd0);
        push(1, 0, 1'b0, 16'h00ff); push(1, 0, 1'b0, 16'h00ff);
        push(1, 0, 1'b0, 16'h00ff); push(1, 1, 1'b0, 16'h00fe);
        run_both(1, 3, 1);

        // timeout with ready stuck high
        stuck[0] = 1'b1;
        set_port(0, 0, 1'b1, 1'b0, 25'd0, 16'd0);
        push(0, 0, 1'b1, 16'h00ff);
        nref = 0;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (c_ref[0]) nref++;
            if (ack0[0]) break;
        end
        chk("timeout_ref_cycles", nref, 16);
        chk("timeout_ref_low", {31'd0, c_ref[0]}, 32'd0);
        set_port(0, 0, 1'b0, 1'b0, 25'd0, 16'd0);
        stuck[0] = 1'b0;
        repeat (2) @(negedge clk);

        // reset during WAIT_DONE abandons the transaction
        set_port(0, 0, 1'b1, 1'b0, 25'd1, 16'd0);
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (busy[0] && !c_rdy[0] && c_ref[0]) break;
        end
        chk("reached_wait_done", n < 50, 1);
        rst_n = 1'b0;
        #1;
        check_zero(0);
        set_port(0, 0, 1'b0, 1'b0, 25'd0, 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        run_op('{0, 0, 1'b0, 25'd1, 16'h0000, 16'h00fe});
        chk("p1_rdata_after_reset", {16'd0, rd1[0]}, 32'd0);

        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
